// File: rtl/mux_select_sequencer_if.sv
// Handshake/select bundle between the round-robin sequencer and its environment.
// The master side is the sequencer; the slave side is the requesters plus the downstream consumer.
interface mux_select_sequencer_if #(
    parameter int unsigned CNT_W = 3
) ();
    logic [3:0]       req;
    logic             out_ready;
    logic [1:0]       sel;
    logic [3:0]       grant;
    logic             out_valid;
    logic [CNT_W-1:0] beat_cnt;

    modport master (
        input  req,
        input  out_ready,
        output sel,
        output grant,
        output out_valid,
        output beat_cnt
    );

    modport slave (
        output req,
        output out_ready,
        input  sel,
        input  grant,
        input  out_valid,
        input  beat_cnt
    );
endinterface

// File: rtl/mux_select_sequencer.sv
// Round-robin select generator for a 4:1 channel mux. Each grant is held for up to
// HOLD_BEATS accepted beats, or until its requester withdraws.
module mux_select_sequencer #(
    parameter int unsigned HOLD_BEATS = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    mux_select_sequencer_if.master  bus
);
    localparam int unsigned CH_N  = 4;
    localparam int unsigned SEL_W = 2;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_BEATS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [CH_N-1:0]    grant_q, grant_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [SEL_W-1:0]   base_c;
    logic               found_c;
    logic [SEL_W-1:0]   idx_c;
    logic               accept_c;
    logic               release_c;

    // Priority base: the channel just served (or the stored pointer when idle) ranks last.
    assign base_c = (state_q == ST_GRANT) ? sel_q : last_q;

    // Scan base+1 .. base+4; iterating downwards lets the nearest hit win.
    always_comb begin
        logic [SEL_W-1:0] cand;
        found_c = 1'b0;
        idx_c   = base_c;
        cand    = base_c;
        for (int k = CH_N; k >= 1; k--) begin
            cand = base_c + SEL_W'(k);
            if (bus.req[cand]) begin
                found_c = 1'b1;
                idx_c   = cand;
            end
        end
    end

    assign accept_c  = valid_q & bus.out_ready;
    assign release_c = (accept_c && (cnt_q == HOLD_LAST)) || !bus.req[sel_q];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        grant_d = grant_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    state_d = ST_GRANT;
                    sel_d   = idx_c;
                    grant_d = CH_N'(1) << idx_c;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (accept_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (release_c) begin
                    last_d = sel_q;
                    cnt_d  = '0;
                    if (found_c) begin
                        sel_d   = idx_c;
                        grant_d = CH_N'(1) << idx_c;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(CH_N - 1);
            grant_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.out_valid = valid_q;
    assign bus.beat_cnt  = cnt_q;
endmodule
